dsp_sample_capture: RTL

Parametrised DSP output capture buffer, the successor to the fixed stereo DAC tap used in DSP test benches. Snoops the DSP's per-sample outputs once per sample period, identified by an edge on `major_step`. Stores whole multi-channel frames in a FIFO with decimation and a selectable full policy. Returns the samples one channel at a time over a valid/ready read port for host or bench consumption.

---
 rtl/dsp_sample_capture.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/dsp_sample_capture.sv
// dsp_sample_capture
// Snoops a DSP's per-sample outputs once per sample period (an edge into
// CAPTURE_STEP on major_step), stores whole multi-channel frames in a FIFO
// with decimation and a selectable full policy, and hands the samples back
// one channel at a time over a valid/ready read port.
//
// Read handshake: rd_valid, rd_data and rd_channel come straight from
// registered state and never depend on rd_ready in the same cycle. A sample
// moves on a rising edge where rd_valid && rd_ready. Once rd_valid is high it
// stays high until the frame's last channel has been taken, with one
// exception: a full-FIFO overwrite discards the head frame and restarts the
// consumer at channel 0 of the next frame. rd_data is 0 when rd_valid is low.

module dsp_sample_capture #(
    parameter int CHANNELS     = 2,
    parameter int SAMPLE_WIDTH = 16,
    parameter int DEPTH        = 16,
    parameter int STEP_WIDTH   = 6,
    parameter int CAPTURE_STEP = 31,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW          = $clog2(DEPTH),
    localparam int LW          = PW + 1,
    localparam int FW          = CHANNELS * SAMPLE_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [FW-1:0]           sample_in,
    input  logic [STEP_WIDTH-1:0]   major_step,
    input  logic                    enable,
    input  logic [3:0]              decimate,
    input  logic                    overwrite,
    input  logic                    clear,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    output logic [CW-1:0]           rd_channel,
    output logic [LW-1:0]           level,
    output logic                    overflow
);

    localparam logic [STEP_WIDTH-1:0] CAP_STEP = STEP_WIDTH'(CAPTURE_STEP);
    localparam logic [CW-1:0]         LAST_CH  = CW'(CHANNELS - 1);
    localparam logic [CW-1:0]         ONE_CH   = CW'(1);
    localparam logic [PW-1:0]         ONE_PTR  = PW'(1);
    localparam logic [LW-1:0]         ONE_LVL  = LW'(1);
    localparam logic [LW-1:0]         FULL_LVL = LW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [STEP_WIDTH-1:0] prev_step_q;
    logic [3:0]            dcnt_q, dcnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         rd_ch_q, rd_ch_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  mem_we;

    // Frame storage; contents are don't-care until written, so no reset.
    logic [FW-1:0]         mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic                    hit;
    logic                    push;
    logic                    xfer;
    logic                    last_ch;
    logic                    pop;
    logic                    full;
    logic [FW-1:0]           head_frame;
    logic [SAMPLE_WIDTH-1:0] head_sample;

    // A hit is the first cycle of CAPTURE_STEP; a held step gives one hit.
    // prev_step resets to 0, so CAPTURE_STEP = 0 out of reset is not a hit.
    assign hit     = (major_step == CAP_STEP) && (prev_step_q != CAP_STEP);
    // Only every (decimate+1)-th enabled hit is stored.
    assign push    = hit && enable && (dcnt_q == 4'd0);
    assign xfer    = rd_valid && rd_ready;
    assign last_ch = (rd_ch_q == LAST_CH);
    // A transfer of the last channel completes the frame and frees its slot.
    assign pop     = xfer && last_ch;
    assign full    = (level_q == FULL_LVL);

    // ------------------------------------------------------------------
    // Read port outputs (registered state only, no path from rd_ready)
    // ------------------------------------------------------------------
    assign head_frame = mem_q[rd_ptr_q];

    // Select the current channel out of the head frame.
    always_comb begin
        head_sample = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (rd_ch_q == CW'(k)) begin
                head_sample = head_frame[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
    end

    assign rd_valid   = (level_q != '0);
    assign rd_data    = rd_valid ? head_sample : '0;
    assign rd_channel = rd_ch_q;
    assign level      = level_q;
    assign overflow   = overflow_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Decimation counter: forced to 0 while disabled, steps once per hit
    // and wraps when it reaches (or has passed) the decimate setting.
    always_comb begin
        dcnt_d = dcnt_q;
        if (clear || !enable) begin
            dcnt_d = 4'd0;
        end else if (hit) begin
            dcnt_d = (dcnt_q >= decimate) ? 4'd0 : dcnt_q + 4'd1;
        end
    end

    // FIFO bookkeeping: read-side advance first, then the push and its
    // full-FIFO policy, with clear overriding everything.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_ch_d    = rd_ch_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            rd_ch_d    = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // Consumer side: step through the channels, pop on the last.
            if (xfer) begin
                if (last_ch) begin
                    rd_ptr_d = rd_ptr_q + ONE_PTR;
                    rd_ch_d  = '0;
                end else begin
                    rd_ch_d  = rd_ch_q + ONE_CH;
                end
            end

            if (push) begin
                if (full && !pop) begin
                    // No room this cycle: a frame is lost either way.
                    overflow_d = 1'b1;
                    if (overwrite) begin
                        // Drop the oldest frame (its slot is the one being
                        // written, since wr_ptr == rd_ptr when full) and
                        // restart the consumer on the next frame.
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_PTR;
                        rd_ptr_d = rd_ptr_q + ONE_PTR;
                        rd_ch_d  = '0;
                    end
                end else begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE_PTR;
                    if (!pop) begin
                        level_d = level_q + ONE_LVL;
                    end
                end
            end else if (pop) begin
                level_d = level_q - ONE_LVL;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Step history for edge detection; deliberately untouched by clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_step_q <= '0;
        end else begin
            prev_step_q <= major_step;
        end
    end

    // Control state: pointers, channel index, level, sticky overflow, dcnt.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dcnt_q     <= 4'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_ch_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            dcnt_q     <= dcnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_ch_q    <= rd_ch_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Frame write: the whole sample_in bus is taken on the hit cycle.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

endmodule
